// File: rtl/program_loader.sv
// Program memory loader: parses an A5/count/words/checksum byte stream, writes the
// words from address 0, zero-fills the remainder and holds the CPU in reset meanwhile.
module program_loader #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            byte_data,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  pm_we,
    output logic [ADDR_WIDTH-1:0] pm_addr,
    output logic [15:0]           pm_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);
    localparam int SIZE = 1 << ADDR_WIDTH;
    localparam int AW   = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {IDLE, COUNT, HI, LO, CHK, FILL, DONE, ERR} state_t;

    state_t        state;
    logic [AW-1:0] addr, cnt, addr_nxt;
    logic [7:0]    hi, acc;
    logic          xfer;

    assign xfer     = byte_valid && byte_ready;
    assign addr_nxt = addr + AW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            byte_ready <= 1'b1;
            pm_we      <= 1'b0;
            pm_addr    <= '0;
            pm_wdata   <= '0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            addr       <= '0;
            cnt        <= '0;
            hi         <= '0;
            acc        <= '0;
        end else begin
            pm_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (xfer && byte_data == 8'hA5) begin
                        state    <= COUNT;
                        cpu_hold <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        addr     <= '0;
                        acc      <= '0;
                    end
                end
                COUNT: begin
                    if (xfer) begin
                        if (byte_data == 8'h00 || int'(byte_data) > SIZE) begin
                            state <= ERR;
                            error <= 1'b1;
                        end else begin
                            cnt   <= AW'(byte_data);
                            state <= HI;
                        end
                    end
                end
                HI: begin
                    if (xfer) begin
                        hi    <= byte_data;
                        acc   <= acc ^ byte_data;
                        state <= LO;
                    end
                end
                LO: begin
                    if (xfer) begin
                        acc      <= acc ^ byte_data;
                        pm_we    <= 1'b1;
                        pm_addr  <= addr[ADDR_WIDTH-1:0];
                        pm_wdata <= {hi, byte_data};
                        addr     <= addr_nxt;
                        state    <= (addr_nxt == cnt) ? CHK : HI;
                    end
                end
                CHK: begin
                    if (xfer) begin
                        if (byte_data != acc) begin
                            state <= ERR;
                            error <= 1'b1;
                        end else if (addr == AW'(SIZE)) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            // first fill write goes out together with the checksum accept
                            state      <= FILL;
                            byte_ready <= 1'b0;
                            pm_we      <= 1'b1;
                            pm_addr    <= addr[ADDR_WIDTH-1:0];
                            pm_wdata   <= '0;
                            addr       <= addr_nxt;
                        end
                    end
                end
                FILL: begin
                    if (addr == AW'(SIZE)) begin
                        state      <= DONE;
                        done       <= 1'b1;
                        cpu_hold   <= 1'b0;
                        byte_ready <= 1'b1;
                    end else begin
                        pm_we    <= 1'b1;
                        pm_addr  <= addr[ADDR_WIDTH-1:0];
                        pm_wdata <= '0;
                        addr     <= addr_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: framed loads, checksum/count errors, gaps, reset.
module tb_program_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready, pm_we, cpu_hold, done, error;
    logic [5:0]  pm_addr;
    logic [15:0] pm_wdata;

    int total = 0;
    int bad = 0;
    logic [15:0] mem [0:63];
    int wcount = 0;
    int rdy_low = 0;

    program_loader #(.ADDR_WIDTH(6)) dut (
        .clk(clk), .rst_n(rst_n), .byte_data(byte_data), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pm_we) begin
            mem[pm_addr] <= pm_wdata;
            wcount <= wcount + 1;
        end
    end

    always @(negedge clk) if (!byte_ready) rdy_low <= rdy_low + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns one cycle after the transfer edge, i.e. where registered results show.
    task automatic send(input logic [7:0] b);
        int n = 0;
        byte_data  = b;
        byte_valid = 1'b1;
        while (!byte_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 200) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_gap(input logic [7:0] b);
        repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
        end
        send(b);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ready"}, 32'(byte_ready), 32'd1);
        chk({tag, "_we"},    32'(pm_we),      32'd0);
        chk({tag, "_addr"},  32'(pm_addr),    32'd0);
        chk({tag, "_wdata"}, 32'(pm_wdata),   32'd0);
        chk({tag, "_hold"},  32'(cpu_hold),   32'd0);
        chk({tag, "_done"},  32'(done),       32'd0);
        chk({tag, "_error"}, 32'(error),      32'd0);
    endtask

    initial begin
        int base, rbase, zeros;
        logic [7:0] cs, lo;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outs("reset");
        rst_n = 1'b1;

        // junk before header is ignored
        send(8'h00); send(8'hFF); send(8'h12);
        chk("junk_hold", 32'(cpu_hold), 32'd0);
        chk("junk_writes", 32'(wcount), 32'd0);

        // valid N=2 load with zero-fill
        base = wcount;
        send(8'hA5);
        chk("hdr_hold", 32'(cpu_hold), 32'd1);
        send(8'h02); send(8'hB2); send(8'h03);
        chk("w0_we", 32'(pm_we), 32'd1);
        chk("w0_addr", 32'(pm_addr), 32'd0);
        chk("w0_data", 32'(pm_wdata), 32'hB203);
        send(8'hB3); send(8'h05);
        chk("w1_addr", 32'(pm_addr), 32'd1);
        chk("w1_data", 32'(pm_wdata), 32'hB305);
        send(8'h07);
        chk("fill_ready", 32'(byte_ready), 32'd0);
        chk("fill_first", {pm_we, 9'd0, pm_addr, pm_wdata}, {1'b1, 9'd0, 6'd2, 16'h0000});
        repeat (61) begin @(posedge clk); #1; end
        chk("fill_last", {pm_we, done, cpu_hold, 7'd0, pm_addr}, {1'b1, 1'b0, 1'b1, 7'd0, 6'd63});
        @(posedge clk); #1;
        chk("n2_done", {done, cpu_hold, error, byte_ready, pm_we}, 5'b10010);
        chk("n2_count", 32'(wcount - base), 32'd64);
        chk("n2_mem0", 32'(mem[0]), 32'hB203);
        chk("n2_mem1", 32'(mem[1]), 32'hB305);
        zeros = 0;
        for (int k = 2; k < 64; k++) if (mem[k] === 16'h0000) zeros++;
        chk("n2_zeros", 32'(zeros), 32'd62);

        // bad checksum
        base = wcount;
        send(8'hA5);
        chk("bad_done_clr", 32'(done), 32'd0);
        send(8'h02); send(8'hB2); send(8'h03); send(8'hB3); send(8'h05); send(8'h08);
        chk("bad_flags", {error, cpu_hold, done, pm_we}, 4'b1100);
        repeat (5) begin @(posedge clk); #1; end
        chk("bad_writes", 32'(wcount - base), 32'd2);

        // recovery with random gaps: 1234 ABCD 00FF, checksum BF
        base = wcount;
        send_gap(8'hA5);
        chk("rec_err_clr", {error, cpu_hold}, 2'b01);
        send_gap(8'h03);
        send_gap(8'h12); send_gap(8'h34); send_gap(8'hAB);
        send_gap(8'hCD); send_gap(8'h00); send_gap(8'hFF);
        send_gap(8'hBF);
        wait_done("rec_done");
        chk("rec_err", 32'(error), 32'd0);
        chk("rec_mem", {mem[0], mem[1]}, {16'h1234, 16'hABCD});
        chk("rec_mem2", {16'd0, mem[2]}, {16'd0, 16'h00FF});
        chk("rec_mem3", 32'(mem[3]), 32'h0000);
        chk("rec_count", 32'(wcount - base), 32'd64);

        // illegal counts
        base = wcount;
        send(8'hA5); send(8'h00);
        chk("cnt0_err", {error, cpu_hold, done}, 3'b110);
        send(8'hA5); send(8'h41);
        chk("cnt65_err", {error, cpu_hold, done}, 3'b110);
        repeat (3) begin @(posedge clk); #1; end
        chk("cnt_writes", 32'(wcount - base), 32'd0);

        // full N=64 load, no fill
        base  = wcount;
        rbase = rdy_low;
        cs    = 8'h00;
        send(8'hA5); send(8'h40);
        chk("cnt64_ok", 32'(error), 32'd0);
        for (int i = 0; i < 64; i++) begin
            lo = 8'(i * 3);
            cs = cs ^ 8'(i) ^ lo;
            send(8'(i));
            send(lo);
        end
        send(cs);
        chk("full_done", {done, cpu_hold, error, pm_we}, 4'b1000);
        chk("full_count", 32'(wcount - base), 32'd64);
        chk("full_ready", 32'(rdy_low - rbase), 32'd0);
        chk("full_mem5", 32'(mem[5]), 32'h050F);
        chk("full_mem63", 32'(mem[63]), 32'h3FBD);

        // reset mid-load
        send(8'hA5); send(8'h02); send(8'hB2);
        chk("mid_hold", 32'(cpu_hold), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk_reset_outs("midrst");
        rst_n = 1'b1;
        base = wcount;
        send(8'hA5); send(8'h01); send(8'h12); send(8'h34);
        chk("post_w0", {pm_we, 9'd0, pm_addr, pm_wdata}, {1'b1, 9'd0, 6'd0, 16'h1234});
        send(8'h26);
        wait_done("post_done");
        chk("post_mem", {mem[0], mem[1]}, {16'h1234, 16'h0000});
        chk("post_count", 32'(wcount - base), 32'd64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
